// File: rtl/rtds_sequencer.sv
// rtds_sequencer: brake-sensor evaluation, start-button conditioning and the
// ready-to-drive state machine (IDLE -> HORN -> DRIVE) for the vehicle
// control FPGA. All outputs come straight from registers.
module rtds_sequencer #(
  parameter int               ADC_W        = 12,
  parameter int               N_BSE        = 2,
  parameter logic [ADC_W-1:0] BRAKE_ON     = ADC_W'(100),
  parameter logic [ADC_W-1:0] BRAKE_HYST   = ADC_W'(10),
  parameter logic [ADC_W-1:0] BSE_MIN      = ADC_W'(10),
  parameter logic [ADC_W-1:0] BSE_MAX      = ADC_W'(4000),
  parameter int               DEBOUNCE_CYC = 500000,
  parameter int               HORN_CYC     = 100000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SDC_final,
  input  logic [N_BSE*ADC_W-1:0] BSE,
  input  logic                   start_button,
  output logic                   brake_light,
  output logic                   speaker,
  output logic                   ready_to_drive,
  output logic                   bse_fault,
  output logic [1:0]             rtd_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HORN  = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam int               DB_W      = $clog2(DEBOUNCE_CYC + 1);
  localparam int               HC_W      = $clog2(HORN_CYC + 1);
  // Counters fire on the last cycle of the interval so the transition lands
  // exactly DEBOUNCE_CYC / HORN_CYC edges after the interval starts.
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HC_W-1:0]  HORN_LAST = HC_W'(HORN_CYC - 1);
  localparam logic [ADC_W-1:0] REL_THR   = BRAKE_ON - BRAKE_HYST;

  // Synchronisers
  logic [1:0]      sdc_sync_q, btn_sync_q;
  logic            sdc_s, btn_s;

  // Brake sensor evaluation
  logic [N_BSE-1:0] ch_fault, ch_hi, ch_lo;
  logic             brake_q, brake_d;
  logic             fault_q;
  logic             brake_light_q;

  // Debounce / edge detect
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_db_q, btn_db_d;
  logic            btn_db_dly_q;
  logic            start_ev;

  // FSM
  state_t          state_q, state_d;
  logic [HC_W-1:0] horn_cnt_q, horn_cnt_d;
  logic            speaker_q, rtd_q;

  assign sdc_s = sdc_sync_q[1];
  assign btn_s = btn_sync_q[1];

  // Per-channel classification; a faulted channel never votes "pressed" and
  // never blocks a release.
  for (genvar i = 0; i < N_BSE; i++) begin : g_ch
    logic [ADC_W-1:0] smp;
    assign smp         = BSE[i*ADC_W +: ADC_W];
    assign ch_fault[i] = (smp < BSE_MIN) || (smp > BSE_MAX);
    assign ch_hi[i]    = !ch_fault[i] && (smp > BRAKE_ON);
    assign ch_lo[i]    = ch_fault[i] || (smp <= REL_THR);
  end

  // Brake hysteresis: all-faulted forces release, then set beats clear.
  always_comb begin
    brake_d = brake_q;
    if (&ch_fault)   brake_d = 1'b0;
    else if (|ch_hi) brake_d = 1'b1;
    else if (&ch_lo) brake_d = 1'b0;
  end

  // Debounce: btn_db follows btn_s only after DEBOUNCE_CYC consecutive disagreeing cycles.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign start_ev = btn_db_q & ~btn_db_dly_q;

  // Ready-to-drive next state; an open shutdown circuit overrides everything.
  always_comb begin
    state_d    = state_q;
    horn_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (start_ev && brake_q && sdc_s && !fault_q) state_d = HORN;
      end
      HORN: begin
        if (horn_cnt_q == HORN_LAST) state_d = DRIVE;
        else                         horn_cnt_d = horn_cnt_q + 1'b1;
      end
      DRIVE:   state_d = DRIVE;
      default: state_d = IDLE;
    endcase
    if (!sdc_s) begin
      state_d    = IDLE;
      horn_cnt_d = '0;
    end
  end

  // All state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdc_sync_q    <= '0;
      btn_sync_q    <= '0;
      brake_q       <= 1'b0;
      fault_q       <= 1'b0;
      brake_light_q <= 1'b1;
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      btn_db_dly_q  <= 1'b0;
      state_q       <= IDLE;
      horn_cnt_q    <= '0;
      speaker_q     <= 1'b1;
      rtd_q         <= 1'b0;
    end else begin
      sdc_sync_q    <= {sdc_sync_q[0], SDC_final};
      btn_sync_q    <= {btn_sync_q[0], start_button};
      brake_q       <= brake_d;
      fault_q       <= |ch_fault;
      brake_light_q <= ~brake_d;
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_dly_q  <= btn_db_q;
      state_q       <= state_d;
      horn_cnt_q    <= horn_cnt_d;
      speaker_q     <= (state_d != HORN);
      rtd_q         <= (state_d != IDLE);
    end
  end

  assign brake_light    = brake_light_q;
  assign speaker        = speaker_q;
  assign ready_to_drive = rtd_q;
  assign bse_fault      = fault_q;
  assign rtd_state      = state_q;

endmodule

// File: tb/tb_rtds_sequencer.sv
// Bench for rtds_sequencer: brake/fault vector table, directed start-up and
// shutdown sequences, then randomized traffic against a behavioural model.
module tb_rtds_sequencer;

  localparam int DEB  = 4;
  localparam int HORN = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        SDC_final;
  logic [23:0] BSE;
  logic        start_button;
  logic        brake_light, speaker, ready_to_drive, bse_fault;
  logic [1:0]  rtd_state;

  int checks   = 0;
  int failures = 0;
  bit mchk_en  = 1'b0;

  rtds_sequencer #(
    .ADC_W(12), .N_BSE(2), .BRAKE_ON(12'd100), .BRAKE_HYST(12'd10),
    .BSE_MIN(12'd10), .BSE_MAX(12'd4000), .DEBOUNCE_CYC(DEB), .HORN_CYC(HORN)
  ) dut (
    .clk(clk), .rst(rst), .SDC_final(SDC_final), .BSE(BSE),
    .start_button(start_button), .brake_light(brake_light), .speaker(speaker),
    .ready_to_drive(ready_to_drive), .bse_fault(bse_fault), .rtd_state(rtd_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural reference model ----------------
  // Inputs reach the logic two clocks late; the debounced level follows the
  // synchronised level once it has disagreed for DEB cycles in a row; state
  // 0/1/2 = idle/horn/drive with m_horn counting cycles already spent in horn.
  bit [1:0] m_sdc_pipe, m_btn_pipe;
  bit       m_db, m_db_prev, m_brake, m_fault;
  int       m_run, m_state, m_horn;

  always @(posedge clk) begin : model
    bit sdc_now, btn_now, ev, hi_any, all_low;
    int nvalid, v;
    if (rst) begin
      m_sdc_pipe = 2'b00; m_btn_pipe = 2'b00;
      m_db = 0; m_db_prev = 0; m_run = 0;
      m_brake = 0; m_fault = 0; m_state = 0; m_horn = 0;
    end else begin
      sdc_now = m_sdc_pipe[1];
      btn_now = m_btn_pipe[1];
      ev      = m_db && !m_db_prev;
      if (!sdc_now) begin
        m_state = 0; m_horn = 0;
      end else if (m_state == 0) begin
        if (ev && m_brake && !m_fault) begin m_state = 1; m_horn = 0; end
      end else if (m_state == 1) begin
        m_horn = m_horn + 1;
        if (m_horn == HORN) begin m_state = 2; m_horn = 0; end
      end
      m_db_prev = m_db;
      if (btn_now != m_db) begin
        m_run = m_run + 1;
        if (m_run == DEB) begin m_db = btn_now; m_run = 0; end
      end else m_run = 0;
      nvalid = 0; hi_any = 0; all_low = 1;
      for (int i = 0; i < 2; i++) begin
        v = int'(BSE[i*12 +: 12]);
        if (v >= 10 && v <= 4000) begin
          nvalid++;
          if (v > 100) hi_any = 1;
          if (v > 90)  all_low = 0;
        end
      end
      m_fault = (nvalid != 2);
      if (nvalid == 0)  m_brake = 0;
      else if (hi_any)  m_brake = 1;
      else if (all_low) m_brake = 0;
      m_sdc_pipe = {m_sdc_pipe[0], SDC_final};
      m_btn_pipe = {m_btn_pipe[0], start_button};
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (mchk_en) begin
      chk("model_brake_light", int'(brake_light), int'(!m_brake));
      chk("model_bse_fault", int'(bse_fault), int'(m_fault));
      chk("model_rtd_state", int'(rtd_state), m_state);
      chk("model_speaker", int'(speaker), int'(m_state != 1));
      chk("model_ready", int'(ready_to_drive), int'(m_state != 0));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(input string nm, input int s, input int limit);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (int'(rtd_state) == s) break;
    end
    chk(nm, int'(rtd_state), s);
  endtask

  function automatic logic [11:0] rnd_sample();
    case ($urandom_range(0, 17))
      0: return 12'd0;     1: return 12'd5;     2: return 12'd9;
      3: return 12'd10;    4: return 12'd11;    5: return 12'd50;
      6: return 12'd89;    7: return 12'd90;    8: return 12'd91;
      9: return 12'd95;    10: return 12'd100;  11: return 12'd101;
      12: return 12'd150;  13: return 12'd200;  14: return 12'd3999;
      15: return 12'd4000; 16: return 12'd4001;
      default: return 12'(int'($urandom_range(0, 4095)));
    endcase
  endfunction

  typedef struct {
    logic [11:0] b0;
    logic [11:0] b1;
    logic        bl;
    logic        flt;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // {ch0, ch1, expected brake_light, expected bse_fault}; applied in order.
    vecs[0]  = '{12'd200,  12'd200,  1'b0, 1'b0};
    vecs[1]  = '{12'd95,   12'd95,   1'b0, 1'b0};
    vecs[2]  = '{12'd90,   12'd90,   1'b1, 1'b0};
    vecs[3]  = '{12'd95,   12'd95,   1'b1, 1'b0};
    vecs[4]  = '{12'd101,  12'd95,   1'b0, 1'b0};
    vecs[5]  = '{12'd91,   12'd91,   1'b0, 1'b0};
    vecs[6]  = '{12'd10,   12'd10,   1'b1, 1'b0};
    vecs[7]  = '{12'd9,    12'd200,  1'b0, 1'b1};
    vecs[8]  = '{12'd200,  12'd4095, 1'b0, 1'b1};
    vecs[9]  = '{12'd5,    12'd4095, 1'b1, 1'b1};
    vecs[10] = '{12'd4000, 12'd4001, 1'b0, 1'b1};
    vecs[11] = '{12'd4000, 12'd4000, 1'b0, 1'b0};
    vecs[12] = '{12'd50,   12'd4095, 1'b1, 1'b1};
    vecs[13] = '{12'd100,  12'd100,  1'b1, 1'b0};
    vecs[14] = '{12'd101,  12'd101,  1'b0, 1'b0};
    vecs[15] = '{12'd0,    12'd0,    1'b1, 1'b1};

    // Reset with arbitrary inputs
    rst = 1'b1; SDC_final = 1'b1; start_button = 1'b1;
    BSE = {rnd_sample(), 12'd200};
    tick();
    mchk_en = 1'b1;
    ticks(2);
    chk("reset_brake_light", int'(brake_light), 1);
    chk("reset_speaker", int'(speaker), 1);
    chk("reset_ready", int'(ready_to_drive), 0);
    chk("reset_bse_fault", int'(bse_fault), 0);
    chk("reset_rtd_state", int'(rtd_state), 0);
    rst = 1'b0; SDC_final = 1'b0; start_button = 1'b0; BSE = '0;
    ticks(4);

    // Brake hysteresis and plausibility table, one clock latency each
    for (int i = 0; i < 16; i++) begin
      BSE = {vecs[i].b1, vecs[i].b0};
      tick();
      chk($sformatf("vec%0d_brake_light", i), int'(brake_light), int'(vecs[i].bl));
      chk($sformatf("vec%0d_bse_fault", i), int'(bse_fault), int'(vecs[i].flt));
    end

    // Start-up: ready exactly DEB+2 edges after the first sampling edge
    BSE = {12'd200, 12'd200}; SDC_final = 1'b1; start_button = 1'b0;
    ticks(4);
    start_button = 1'b1;
    for (int i = 0; i <= DEB + 1; i++) begin
      tick();
      chk($sformatf("startup_edge%0d_ready_low", i), int'(ready_to_drive), 0);
    end
    tick();
    chk("startup_ready_high", int'(ready_to_drive), 1);
    chk("startup_speaker_on", int'(speaker), 0);
    chk("startup_state_horn", int'(rtd_state), 1);
    for (int i = 1; i < HORN; i++) begin
      tick();
      chk($sformatf("horn_cyc%0d_speaker", i), int'(speaker), 0);
      chk($sformatf("horn_cyc%0d_ready", i), int'(ready_to_drive), 1);
    end
    tick();
    chk("drive_speaker_off", int'(speaker), 1);
    chk("drive_state", int'(rtd_state), 2);
    chk("drive_ready", int'(ready_to_drive), 1);

    // Shutdown opens in DRIVE: three edges to drop out
    SDC_final = 1'b0;
    ticks(2);
    chk("sdc_drop_edge2_ready", int'(ready_to_drive), 1);
    tick();
    chk("sdc_drop_edge3_ready", int'(ready_to_drive), 0);
    chk("sdc_drop_edge3_state", int'(rtd_state), 0);

    // Shutdown opens during horn cycle 3
    start_button = 1'b0; SDC_final = 1'b1;
    ticks(2 * DEB);
    start_button = 1'b1;
    wait_state("horn_reentry", 1, 12);
    ticks(2);
    SDC_final = 1'b0;
    ticks(2);
    chk("horn_drop_edge2_speaker", int'(speaker), 0);
    tick();
    chk("horn_drop_ready", int'(ready_to_drive), 0);
    chk("horn_drop_speaker", int'(speaker), 1);
    chk("horn_drop_state", int'(rtd_state), 0);
    SDC_final = 1'b1;
    ticks(10);
    chk("held_button_no_retrigger", int'(rtd_state), 0);
    start_button = 1'b0;
    ticks(2 * DEB);
    start_button = 1'b1;
    ticks(2);
    start_button = 1'b0;
    ticks(10);
    chk("glitch_no_start", int'(rtd_state), 0);
    start_button = 1'b1;
    wait_state("press_after_glitch", 1, 12);
    start_button = 1'b0; SDC_final = 1'b0;
    ticks(8);

    // Start press without brake is consumed
    BSE = {12'd50, 12'd50}; SDC_final = 1'b1;
    ticks(8);
    start_button = 1'b1;
    ticks(10);
    chk("no_brake_stays_idle", int'(rtd_state), 0);
    BSE = {12'd200, 12'd200};
    ticks(10);
    chk("late_brake_stays_idle", int'(rtd_state), 0);
    chk("late_brake_light_on", int'(brake_light), 0);
    start_button = 1'b0;
    ticks(2 * DEB);
    start_button = 1'b1;
    wait_state("repress_enters_horn", 1, 12);
    start_button = 1'b0; SDC_final = 1'b0;
    ticks(8);

    // Faulted sensor blocks entry
    BSE = {12'd4095, 12'd200}; SDC_final = 1'b1;
    tick();
    chk("fault_flag", int'(bse_fault), 1);
    chk("fault_brake_light_ch0", int'(brake_light), 0);
    start_button = 1'b1;
    ticks(12);
    chk("fault_blocks_entry", int'(rtd_state), 0);
    BSE = {12'd4095, 12'd5};
    tick();
    chk("all_fault_brake_released", int'(brake_light), 1);
    start_button = 1'b0;
    ticks(8);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (SDC_final) begin
        if ($urandom_range(0, 59) == 0) SDC_final = 1'b0;
      end else if ($urandom_range(0, 4) == 0) SDC_final = 1'b1;
      if ($urandom_range(0, 5) == 0) start_button = ~start_button;
      if ($urandom_range(0, 3) == 0) BSE = {rnd_sample(), rnd_sample()};
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
